// File: rtl/filter_engine.sv
`default_nettype none
// ============================================================================
// Module  : filter_engine
// Purpose : Reads a grayscale frame, applies copy/invert/3x3 Gaussian/threshold
//           and writes one pixel per write into the display frame RAM.
// Rev     : 1.0  initial release
// ============================================================================
module filter_engine #(
  parameter int          WIDTH  = 100,
  parameter int          HEIGHT = 100,
  parameter int          AW     = 14,
  parameter logic [7:0]  THRESH = 8'd128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_q,
  output logic [AW-1:0] dst_addr,
  output logic [31:0]   dst_data,
  output logic          dst_wren,
  output logic          busy,
  output logic          done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] ROW_STEP = AW'(WIDTH);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_INMAX  = XW'(WIDTH - 2);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_INMAX  = YW'(HEIGHT - 2);

  logic [2:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_q, row_d;
  logic [11:0]   acc_q, acc_d;
  logic [3:0]    tap_q, tap_d;
  logic [7:0]    pix_q, pix_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [7:0]    dst_data_q, dst_data_d;

  logic          interior;
  logic [3:0]    first_tap, last_tap;
  logic          cap_en;
  logic [3:0]    cap_idx;
  logic [11:0]   weighted;
  logic [7:0]    result;

  function automatic logic is_interior(input logic [1:0] m, input logic [XW-1:0] xx,
                                       input logic [YW-1:0] yy);
    return (m == 2'd2) && (xx >= XW'(1)) && (xx <= X_INMAX) &&
           (yy >= YW'(1)) && (yy <= Y_INMAX);
  endfunction

  // Tap t walks the 3x3 window row-major; tap 4 is the centre pixel.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] c, input logic [3:0] t);
    case (t)
      4'd0:    return c - ROW_STEP - ONE_A;
      4'd1:    return c - ROW_STEP;
      4'd2:    return c - ROW_STEP + ONE_A;
      4'd3:    return c - ONE_A;
      4'd5:    return c + ONE_A;
      4'd6:    return c + ROW_STEP - ONE_A;
      4'd7:    return c + ROW_STEP;
      4'd8:    return c + ROW_STEP + ONE_A;
      default: return c;
    endcase
  endfunction

  assign interior  = is_interior(mode_q, x_q, y_q);
  assign first_tap = interior ? 4'd0 : 4'd4;
  assign last_tap  = interior ? 4'd8 : 4'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      tap_q      <= '0;
      pix_q      <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      pix_q      <= pix_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (tap_q == last_tap) state_d = S_WAIT;
      S_WAIT:  state_d = S_WRITE;
      S_WRITE: state_d = (x_q == X_LAST && y_q == Y_LAST) ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (cap_idx)
      4'd4:                      weighted = {2'b0, src_q, 2'b0};
      4'd1, 4'd3, 4'd5, 4'd7:    weighted = {3'b0, src_q, 1'b0};
      default:                   weighted = {4'b0, src_q};
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    row_d      = row_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    pix_d      = pix_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    cap_en     = 1'b0;
    cap_idx    = tap_q;
    result     = pix_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          x_d    = '0;
          y_d    = '0;
          row_d  = '0;
          acc_d  = '0;
        end
      end
      S_READ: begin
        // src_q lags the address by one cycle, so capture the previous tap.
        if (tap_q != first_tap) begin
          cap_en  = 1'b1;
          cap_idx = tap_q - 4'd1;
        end
        if (tap_q != last_tap) tap_d = tap_q + 4'd1;
      end
      S_WAIT: begin
        cap_en     = 1'b1;
        cap_idx    = tap_q;
        dst_addr_d = row_q + AW'(x_q);
      end
      S_WRITE: begin
        acc_d = '0;
        if (x_q == X_LAST) begin
          x_d   = '0;
          y_d   = y_q + YW'(1);
          row_d = row_q + ROW_STEP;
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      default: ;
    endcase

    if (cap_en) begin
      acc_d = acc_q + weighted;
      if (cap_idx == 4'd4) pix_d = src_q;
    end

    case (mode_q)
      2'd1:    result = 8'hFF - pix_d;
      2'd2:    result = interior ? acc_d[11:4] : pix_d;
      2'd3:    result = (pix_d >= THRESH) ? 8'hFF : 8'h00;
      default: result = pix_d;
    endcase
    if (state_q == S_WAIT) dst_data_d = result;

    // Entering READ: pick the first tap from the pixel about to be processed.
    if (state_d == S_READ && state_q != S_READ)
      tap_d = is_interior(mode_d, x_d, y_d) ? 4'd0 : 4'd4;
    if (state_d == S_READ)
      src_addr_d = tap_addr(row_d + AW'(x_d), tap_d);
  end

  always_comb begin
    dst_wren = (state_q == S_WRITE);
    busy     = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
    done     = (state_q == S_DONE);
  end

  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = {24'b0, dst_data_q};

endmodule
`default_nettype wire

// File: doc/filter_engine.md
Name: filter_engine

Overview:
- Upstream stage of the VGA display path. On a start pulse it reads a WIDTH x HEIGHT 8-bit grayscale source image from a read-only frame memory.
- It applies one of four pixel filters and writes the result, one pixel per write, into the display frame RAM (32-bit words, pixel in bits [7:0]) that the video generator scans.
- It runs in the VGA pixel clock domain and is the only writer of the display RAM.

Parameters:
- WIDTH, 100, image width in pixels
- HEIGHT, 100, image height in pixels
- AW, 14, address width; must satisfy 2^AW >= WIDTH*HEIGHT
- THRESH, 8'd128, threshold for mode 3

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  1-cycle request to filter a whole frame
- mode  in  2  0 copy, 1 invert, 2 3x3 Gaussian, 3 threshold; sampled with start
- src_addr  out  AW  source memory read address
- src_q  in  8  source pixel; valid the cycle after src_addr is driven (1-cycle registered-address RAM)
- dst_addr  out  AW  display RAM write address
- dst_data  out  32  write data; bits [31:8] always 0
- dst_wren  out  1  display RAM write enable, 1-cycle pulse per pixel
- busy  out  1  high while a frame is being processed
- done  out  1  1-cycle pulse when the frame is complete

Behaviour:
- Reset (async, immediate): src_addr=0, dst_addr=0, dst_data=0, dst_wren=0, busy=0, done=0, FSM=IDLE, x=y=0, accumulator=0.
- Addressing: address = y*WIDTH + x, raster order (x fastest). Maintain a row-base register stepped by WIDTH; no multiplier.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: start=1 latches mode, clears x, y and the accumulator, then goes to READ next cycle. start is ignored in every other state. mode changes are ignored after the latch.
- Tap count per pixel: 9 for mode 2 when the pixel is interior (1<=x<=WIDTH-2 and 1<=y<=HEIGHT-2). Otherwise 1 (centre pixel only).
- READ: drives one tap address per cycle; from the second READ cycle onward captures the src_q of the previous tap.
  - Tap order is row-major from (x-1,y-1) to (x+1,y+1).
  - Weights are 1 2 1 / 2 4 2 / 1 2 1. The accumulator is 12 bits (max 4080), so no overflow.
  - After the last tap address, go to WAIT.
- WAIT: captures the final tap, then goes to WRITE.
- WRITE: asserts dst_wren=1 for exactly one cycle, with dst_addr = centre address and dst_data = {24'b0, result}.
  - Mode 0: result = p.
  - Mode 1: result = 255 - p.
  - Mode 2 interior: result = acc[11:4] (truncating /16).
  - Mode 2 border: result = p, copied unmodified.
  - Mode 3: result = (p >= THRESH) ? 255 : 0.
  - Then advance x; on wrap x=WIDTH-1 -> 0, y increments. If the pixel was (WIDTH-1, HEIGHT-1), go to DONE; otherwise go to READ with the accumulator cleared.
- Cycles per pixel: 11 for an interior Gaussian pixel (9 READ + WAIT + WRITE); 3 otherwise (READ + WAIT + WRITE).
- busy: 1 from the first READ cycle through the last WRITE cycle inclusive.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- dst_wren is 0 in every state except WRITE; dst_addr and dst_data hold their last values between writes.
- Frame busy length:
  - Modes 0, 1, 3: WIDTH*HEIGHT*3 cycles (30000 with defaults).
  - Mode 2: (WIDTH-2)*(HEIGHT-2)*11 + (WIDTH*HEIGHT-(WIDTH-2)*(HEIGHT-2))*3 cycles (106832 with defaults).
- Reset mid-frame: dst_wren drops immediately and no further write occurs. The partially written frame is left as is, and a new start restarts from pixel (0,0).

Test Plan:
- Reset mid-frame: start mode 0, assert rst at cycle 500 -> dst_wren=0 and busy=0 asynchronously, no done; a later start produces a full 10000-write frame.
- Copy: src[a]=a[7:0], mode 0 -> exactly 10000 dst_wren pulses, dst[a]={24'b0,a[7:0]}, busy high 30000 cycles, one done pulse the cycle after.
- Invert: all src=8'h3C, mode 1 -> every dst_data=32'h000000C3.
- Gaussian: constant 200 image -> all outputs 200. Impulse 255 at (50,50), zeros elsewhere -> dst(50,50)=63, dst(49,50)=31, dst(49,49)=15, dst(47,50)=0. Corner (0,0) with src=7 -> dst(0,0)=7. busy lasts 106832 cycles.
- Threshold: src pixels 127, 128, 255 in mode 3 -> 0, 255, 255.
- Protocol: pulse start with mode 1 while busy in mode 0, and change mode mid-frame -> the frame completes as a copy, write count stays 10000, a single done pulse.
